// File: rtl/cu_pkg.sv
// Control-unit shared types and constants.
// Used by program_counter and instruction_fetch.
package cu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    FAULT
  } fetch_state_t;

  localparam logic [15:0] RESET_ADDR = 16'h1000;

  localparam int FETCH_DATA_W = 8;
  localparam int FETCH_ADDR_W = 16;
  localparam int FETCH_CNT_W  = 16;
  localparam int FETCH_TMR_W  = 8;

endpackage

// File: rtl/fetch_timer.sv
// Memory wait-state counter for the fetch unit.
// Expires once LIMIT-1 unacknowledged cycles have elapsed.
module fetch_timer
  import cu_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [FETCH_TMR_W-1:0] r_cnt;

  localparam logic [FETCH_TMR_W-1:0] LAST =
    FETCH_TMR_W'(LIMIT - 1);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: reads instruction at pc_i, holds it for the
// decoder and pulses the PC advance on acceptance.
module instruction_fetch
  import cu_pkg::*;
#(
  parameter int DATA_W  = FETCH_DATA_W,
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              next_instruction_request,
  output logic              mem_read_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  input  logic              halt_i,
  output logic              fault_o,
  output logic [FETCH_CNT_W-1:0] fetch_count_o
);

  fetch_state_t r_state;
  fetch_state_t w_next;

  logic [DATA_W-1:0]      r_instr;
  logic [ADDR_W-1:0]      r_instr_pc;
  logic                   r_valid;
  logic                   r_fault;
  logic [FETCH_CNT_W-1:0] r_fetch_count;

  logic w_capture;
  logic w_accept;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_expired;

  // Counter is held at zero outside FETCH, so it
  // restarts on every entry to FETCH.
  assign w_tmr_clr = (r_state != FETCH);

  fetch_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .nrst      (nrst),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next                   = r_state;
    mem_read_o               = 1'b0;
    next_instruction_request = 1'b0;
    w_capture                = 1'b0;
    w_accept                 = 1'b0;
    w_tmr_en                 = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!halt_i) w_next = FETCH;
      end
      FETCH: begin
        mem_read_o = 1'b1;
        if (mem_ack_i) begin
          w_capture = 1'b1;
          w_next    = HOLD;
        end else if (w_expired) begin
          w_next = FAULT;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      HOLD: begin
        next_instruction_request = instr_ready_i;
        if (instr_ready_i) begin
          w_accept = 1'b1;
          w_next   = halt_i ? IDLE : FETCH;
        end
      end
      FAULT: begin
        w_next = FAULT;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state       <= IDLE;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_valid       <= 1'b0;
      r_fault       <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_instr       <= mem_rdata_i;
        r_instr_pc    <= pc_i;
        r_valid       <= 1'b1;
        r_fetch_count <= r_fetch_count + 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_next == FAULT) begin
        r_fault <= 1'b1;
        r_valid <= 1'b0;
      end
    end
  end

  assign mem_addr_o    = pc_i;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instr_pc;
  assign instr_valid_o = r_valid;
  assign fault_o       = r_fault;
  assign fetch_count_o = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small
// behavioural program counter in front of it.
module tb_instruction_fetch;

  logic        clk;
  logic        nrst;
  logic [15:0] pc;
  logic        nir;
  logic        mem_read;
  logic [15:0] mem_addr;
  logic        ack;
  logic [7:0]  rdata;
  logic [7:0]  instr;
  logic [15:0] instr_pc;
  logic        valid;
  logic        ready;
  logic        halt;
  logic        fault;
  logic [15:0] fcount;

  logic        cond;
  logic        jmp;
  logic [15:0] absa;

  int n_checks;
  int n_fail;

  instruction_fetch #(
    .DATA_W  (8),
    .ADDR_W  (16),
    .TIMEOUT (16)
  ) dut (
    .clk                      (clk),
    .nrst                     (nrst),
    .pc_i                     (pc),
    .next_instruction_request (nir),
    .mem_read_o               (mem_read),
    .mem_addr_o               (mem_addr),
    .mem_ack_i                (ack),
    .mem_rdata_i              (rdata),
    .instr_o                  (instr),
    .instr_pc_o               (instr_pc),
    .instr_valid_o            (valid),
    .instr_ready_i            (ready),
    .halt_i                   (halt),
    .fault_o                  (fault),
    .fetch_count_o            (fcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural program counter: advance or jump on request.
  always @(posedge clk) begin
    if (!nrst) pc <= 16'h1000;
    else if (nir) pc <= (cond && jmp) ? absa : pc + 16'd1;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({mem_read, nir, valid, fault} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 0000",
               {mem_read, nir, valid, fault});
    end
    n_checks++;
    if ({instr, instr_pc, fcount} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h want 0",
               {instr, instr_pc, fcount});
    end
    nrst = 1'b1;
    n_checks++;
    if (mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_read: got %b want 0", mem_read);
    end
    tick();
    n_checks++;
    if (mem_read !== 1'b1 || mem_addr !== 16'h1000) begin
      n_fail++;
      $display("FAIL first_fetch: got rd=%b a=%h want 1 1000",
               mem_read, mem_addr);
    end
  endtask

  task automatic test_zero_wait();
    ack   = 1'b1;
    rdata = 8'hA5;
    tick();
    ack = 1'b0;
    n_checks++;
    if (instr !== 8'hA5 || instr_pc !== 16'h1000 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL zw_capture: got %h %h %b want a5 1000 1",
               instr, instr_pc, valid);
    end
    n_checks++;
    if (fcount !== 16'd1 || mem_read !== 1'b0 || nir !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_hold: got c=%h rd=%b nir=%b want 1 0 0",
               fcount, mem_read, nir);
    end
    ready = 1'b1;
    #1;
    n_checks++;
    if (nir !== 1'b1) begin
      n_fail++;
      $display("FAIL zw_pulse: got %b want 1", nir);
    end
    tick();
    ready = 1'b0;
    n_checks++;
    if (nir !== 1'b0 || valid !== 1'b0 || mem_read !== 1'b1 ||
        mem_addr !== 16'h1001) begin
      n_fail++;
      $display("FAIL zw_next: got nir=%b v=%b rd=%b a=%h want 0 0 1 1001",
               nir, valid, mem_read, mem_addr);
    end
  endtask

  task automatic test_delayed_ack();
    int  n;
    logic ok;
    n     = 0;
    rdata = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      if (mem_read) n++;
      ack = (i == 3);
      tick();
    end
    ack = 1'b0;
    n_checks++;
    if (n !== 4 || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL dl_read_len: got n=%0d rd=%b want 4 0", n, mem_read);
    end
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (valid !== 1'b1 || nir !== 1'b0) ok = 1'b0;
      tick();
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL dl_hold_stall: got %b want 1", ok);
    end
    n_checks++;
    if (instr !== 8'h3C || instr_pc !== 16'h1001 || fcount !== 16'd2) begin
      n_fail++;
      $display("FAIL dl_capture: got %h %h %h want 3c 1001 0002",
               instr, instr_pc, fcount);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_branch();
    ack   = 1'b1;
    rdata = 8'h11;
    tick();
    ack  = 1'b0;
    cond = 1'b1;
    jmp  = 1'b1;
    absa = 16'h7843;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    cond  = 1'b0;
    jmp   = 1'b0;
    n_checks++;
    if (mem_read !== 1'b1 || mem_addr !== 16'h7843) begin
      n_fail++;
      $display("FAIL branch_addr: got rd=%b a=%h want 1 7843",
               mem_read, mem_addr);
    end
  endtask

  task automatic test_halt_wrap();
    halt = 1'b1;
    tick();
    n_checks++;
    if (mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_no_abort: got %b want 1", mem_read);
    end
    ack   = 1'b1;
    rdata = 8'h22;
    tick();
    ack = 1'b0;
    n_checks++;
    if (valid !== 1'b1 || instr !== 8'h22 || instr_pc !== 16'h7843) begin
      n_fail++;
      $display("FAIL halt_keep: got v=%b %h %h want 1 22 7843",
               valid, instr, instr_pc);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    n_checks++;
    if (mem_read !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_idle: got rd=%b v=%b want 0 0", mem_read, valid);
    end
    force dut.r_fetch_count = 16'hFFFE;
    #1;
    release dut.r_fetch_count;
    halt = 1'b0;
    tick();
    n_checks++;
    if (mem_read !== 1'b1 || mem_addr !== 16'h7844) begin
      n_fail++;
      $display("FAIL unhalt_fetch: got rd=%b a=%h want 1 7844",
               mem_read, mem_addr);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (fcount !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL cnt_ffff: got %h want ffff", fcount);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    ack   = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (fcount !== 16'h0000) begin
      n_fail++;
      $display("FAIL cnt_wrap: got %h want 0000", fcount);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 24; i++) begin
      if (mem_read) n++;
      tick();
    end
    n_checks++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL to_read_len: got %0d want 16", n);
    end
    n_checks++;
    if (fault !== 1'b1 || mem_read !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL to_fault: got f=%b rd=%b v=%b want 1 0 0",
               fault, mem_read, valid);
    end
    ack   = 1'b1;
    rdata = 8'hFF;
    tick();
    tick();
    ack = 1'b0;
    n_checks++;
    if (fault !== 1'b1 || fcount !== 16'd0 || instr !== 8'h00 ||
        valid !== 1'b0 || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL to_late_ack: got f=%b c=%h i=%h v=%b rd=%b want 1 0 0 0 0",
               fault, fcount, instr, valid, mem_read);
    end
    nrst = 1'b0;
    tick();
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL to_reset_clr: got %b want 0", fault);
    end
    nrst = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nrst  = 1'b0;
    ack   = 1'b0;
    rdata = 8'h00;
    ready = 1'b0;
    halt  = 1'b0;
    cond  = 1'b0;
    jmp   = 1'b0;
    absa  = 16'h0000;
    test_reset();
    test_zero_wait();
    test_delayed_ack();
    test_branch();
    test_halt_wrap();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
